time_counter: RTL and testbench

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter_pkg.sv | 12 +
 rtl/mod_counter.sv | 47 ++++
 rtl/time_counter.sv | 95 +++++++++
 tb/tb_time_counter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/time_counter_pkg.sv
// Shared field limits and widths for the time-of-day counter.
package time_counter_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter: wrap-around up/down adjust plus a carry-in
// increment whose wrap is reported combinationally on o_cout.
module mod_counter #(
    parameter int W   = 6,
    parameter int MAX = 59
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_cin,
    output logic [W-1:0] o_value,
    output logic         o_cout
);

    localparam logic [W-1:0] L_MAX = W'(MAX);

    logic [W-1:0] r_val;
    logic [W-1:0] w_next;
    logic         w_at_max;

    assign w_at_max = (r_val == L_MAX);

    // An adjust on this field (even a cancelling inc+dec) overrides the carry-in.
    always_comb begin
        w_next = r_val;
        if (i_inc && !i_dec) begin
            w_next = w_at_max ? '0 : r_val + 1'b1;
        end else if (i_dec && !i_inc) begin
            w_next = (r_val == '0) ? L_MAX : r_val - 1'b1;
        end else if (!i_inc && !i_dec && i_cin) begin
            w_next = w_at_max ? '0 : r_val + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_val <= '0;
        end else begin
            r_val <= w_next;
        end
    end

    assign o_value = r_val;
    assign o_cout  = i_cin && !i_inc && !i_dec && w_at_max;

endmodule

// File: rtl/time_counter.sv
// HH:MM:SS timekeeper: prescaler-driven seconds tick with ripple carry,
// per-field adjust pulses, and a one-deep deferral of ticks that collide with adjusts.
module time_counter
    import time_counter_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              up_seg,
    input  logic              up_min,
    input  logic              up_hour,
    input  logic              down_seg,
    input  logic              down_min,
    input  logic              down_hour,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic              sec_tick
);

    localparam int              PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] r_presc;
    logic             r_pending;
    logic             r_sec_tick;
    logic             w_tick;
    logic             w_any_adj;
    logic             w_apply;
    logic             w_sec_cout;
    logic             w_min_cout;
    logic             w_hour_cout;

    assign w_tick    = run && (r_presc == PRE_MAX);
    assign w_any_adj = up_seg | up_min | up_hour | down_seg | down_min | down_hour;
    // A tick (fresh or deferred) advances time only in a cycle free of adjusts.
    assign w_apply   = (w_tick || r_pending) && !w_any_adj;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
        end else if (run) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end

    // Only one tick is remembered; extra ticks during a long adjust burst are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending  <= 1'b0;
            r_sec_tick <= 1'b0;
        end else begin
            r_pending  <= w_any_adj && (r_pending || w_tick);
            r_sec_tick <= w_apply;
        end
    end

    mod_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (up_seg),
        .i_dec   (down_seg),
        .i_cin   (w_apply),
        .o_value (seconds),
        .o_cout  (w_sec_cout)
    );

    mod_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (up_min),
        .i_dec   (down_min),
        .i_cin   (w_sec_cout),
        .o_value (minutes),
        .o_cout  (w_min_cout)
    );

    mod_counter #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
        .i_clk   (clk),
        .i_reset (reset),
        .i_inc   (up_hour),
        .i_dec   (down_hour),
        .i_cin   (w_min_cout),
        .o_value (hours),
        .o_cout  (w_hour_cout)
    );

    assign sec_tick = r_sec_tick;

    logic w_unused;
    assign w_unused = w_hour_cout;

endmodule

// File: tb/tb_time_counter.sv
// Directed bench for time_counter at CLK_HZ=4 with hand-computed expectations.
module tb_time_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       up_seg, up_min, up_hour;
    logic       down_seg, down_min, down_hour;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       sec_tick;

    int n_vec  = 0;
    int n_err  = 0;
    int tick_cnt = 0;

    time_counter #(.CLK_HZ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .up_seg    (up_seg),
        .up_min    (up_min),
        .up_hour   (up_hour),
        .down_seg  (down_seg),
        .down_min  (down_min),
        .down_hour (down_hour),
        .seconds   (seconds),
        .minutes   (minutes),
        .hours     (hours),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s, input int st);
        check({tag, ".hours"},    int'(hours),    h);
        check({tag, ".minutes"},  int'(minutes),  m);
        check({tag, ".seconds"},  int'(seconds),  s);
        check({tag, ".sec_tick"}, int'(sec_tick), st);
    endtask

    // Advance n rising edges, sampling 1 ns after each and counting sec_tick pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (sec_tick) tick_cnt++;
        end
    endtask

    task automatic clear_adj();
        up_seg = 0; up_min = 0; up_hour = 0;
        down_seg = 0; down_min = 0; down_hour = 0;
    endtask

    task automatic adj(input logic uh, input logic um, input logic us,
                       input logic dh, input logic dm, input logic ds);
        up_hour = uh; up_min = um; up_seg = us;
        down_hour = dh; down_min = dm; down_seg = ds;
        step(1);
        clear_adj();
    endtask

    task automatic do_reset();
        reset = 1;
        step(1);
        reset = 0;
    endtask

    initial begin
        reset = 1;
        run = 0;
        clear_adj();
        step(2);
        reset = 0;
        check_time("reset", 0, 0, 0, 0);

        // Free run: 60th tick lands on edge 240.
        run = 1;
        tick_cnt = 0;
        step(239);
        check("run239.seconds", int'(seconds), 59);
        check("run239.minutes", int'(minutes), 0);
        check("run239.ticks", tick_cnt, 59);
        step(4);
        check_time("run243", 0, 1, 0, 0);
        check("run243.ticks", tick_cnt, 60);
        run = 0;

        // Down-wrap all fields, then up-wrap all fields.
        do_reset();
        check_time("reset2", 0, 0, 0, 0);
        adj(0, 0, 0, 1, 1, 1);
        check_time("down_all", 23, 59, 59, 0);
        adj(1, 1, 1, 0, 0, 0);
        check_time("up_all", 0, 0, 0, 0);
        adj(0, 0, 0, 1, 1, 1);
        check_time("down_all2", 23, 59, 59, 0);

        // Full rollover on a single tick.
        run = 1;
        step(3);
        check_time("pre_roll", 23, 59, 59, 0);
        step(1);
        check_time("rollover", 0, 0, 0, 1);
        run = 0;

        // Tick colliding with up_min at 00:10:05 is deferred one cycle.
        do_reset();
        up_seg = 1; up_min = 1;
        step(5);
        up_seg = 0;
        step(5);
        clear_adj();
        check_time("preload_1005", 0, 10, 5, 0);
        run = 1;
        step(3);
        check_time("pre_collide", 0, 10, 5, 0);
        up_min = 1;
        step(1);
        up_min = 0;
        check_time("collide", 0, 11, 5, 0);
        step(1);
        check_time("deferred", 0, 11, 6, 1);
        step(1);
        check_time("after_def", 0, 11, 6, 0);
        run = 0;

        // Cancelling up/down, and prescaler hold while run=0.
        do_reset();
        up_seg = 1;
        step(30);
        up_seg = 0;
        check("preload30", int'(seconds), 30);
        run = 1;
        step(2);
        run = 0;
        check("presc2.seconds", int'(seconds), 30);
        adj(0, 0, 1, 0, 0, 1);
        check_time("updown_same", 0, 0, 30, 0);
        tick_cnt = 0;
        step(20);
        check("hold20.seconds", int'(seconds), 30);
        check("hold20.ticks", tick_cnt, 0);
        run = 1;
        step(1);
        check_time("resume1", 0, 0, 30, 0);
        step(1);
        check_time("resume2", 0, 0, 31, 1);
        run = 0;

        // Reset clears a pending tick at 12:34:56.
        do_reset();
        for (int i = 0; i < 55; i++) begin
            up_seg  = 1;
            up_min  = (i < 34);
            up_hour = (i < 12);
            step(1);
        end
        clear_adj();
        check_time("preload_123455", 12, 34, 55, 0);
        run = 1;
        step(3);
        up_seg = 1;
        step(1);
        up_seg = 0;
        check_time("pending_123456", 12, 34, 56, 0);
        reset = 1;
        step(1);
        reset = 0;
        check_time("reset_pending", 0, 0, 0, 0);
        tick_cnt = 0;
        step(3);
        check("post_reset.ticks", tick_cnt, 0);
        check("post_reset.seconds", int'(seconds), 0);
        step(1);
        check_time("post_reset_tick", 0, 0, 1, 1);
        run = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
